// File: rtl/gt_rst_seq.sv
// Reset sequencer for one SerDes lane group: PLL reset, lock wait, GT reset,
// reset-done wait and user-logic hold, with bounded retries and a terminal FAIL state.
module gt_rst_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TO_CYC  = 100000,
    parameter int GT_RST_CYC   = 16,
    parameter int DONE_TO_CYC  = 100000,
    parameter int USR_HOLD_CYC = 64,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic       pll_lock,
    input  logic       gt_rst_done,
    output logic       pll_reset,
    output logic       gt_reset,
    output logic       user_reset,
    output logic       seq_done,
    output logic       timeout_err,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_GT_RST,
        S_WAIT_DONE,
        S_USR_HOLD,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TO_CYC - 1);
    localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(GT_RST_CYC - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TO_CYC - 1);
    localparam logic [CNT_W-1:0] USR_LAST  = CNT_W'(USR_HOLD_CYC - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       retry_reg, retry_next;
    logic [1:0]       lock_sync_reg;
    logic             lock_s;
    logic             timeout;

    logic pll_reset_reg, gt_reset_reg, user_reset_reg, seq_done_reg, timeout_err_reg;
    logic pll_reset_next, gt_reset_next, user_reset_next, seq_done_next, timeout_err_next;

    // pll_lock comes from another clock domain; two flops before any use.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            lock_sync_reg <= 2'b00;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], pll_lock};
        end
    end

    assign lock_s = lock_sync_reg[1];

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        timeout    = 1'b0;

        // Within each state, lock loss is tested first and success before timeout.
        case (state_reg)
            S_PLL_RST: begin
                if (cnt_reg == PLL_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s)                      state_next = S_GT_RST;
                else if (cnt_reg == LOCK_LAST)   timeout    = 1'b1;
            end
            S_GT_RST: begin
                if (!lock_s)                     state_next = S_PLL_RST;
                else if (cnt_reg == GT_LAST)     state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!lock_s)                     state_next = S_PLL_RST;
                else if (gt_rst_done)            state_next = S_USR_HOLD;
                else if (cnt_reg == DONE_LAST)   timeout    = 1'b1;
            end
            S_USR_HOLD: begin
                if (!lock_s || !gt_rst_done)     state_next = S_PLL_RST;
                else if (cnt_reg == USR_LAST)    state_next = S_RUN;
            end
            S_RUN: begin
                if (!lock_s || !gt_rst_done)     state_next = S_PLL_RST;
            end
            S_FAIL: begin
                state_next = S_FAIL;
            end
            default: begin
                state_next = S_PLL_RST;
            end
        endcase

        if (timeout) begin
            if (retry_reg < RETRY_MAX) begin
                retry_next = retry_reg + 4'd1;
                state_next = S_PLL_RST;
            end else begin
                state_next = S_FAIL;
            end
        end

        cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);

        // Outputs are decoded from the next state so they register alongside it.
        pll_reset_next   = (state_next == S_PLL_RST) || (state_next == S_FAIL);
        gt_reset_next    = (state_next == S_PLL_RST) || (state_next == S_WAIT_LOCK) ||
                           (state_next == S_GT_RST)  || (state_next == S_FAIL);
        user_reset_next  = (state_next != S_RUN);
        seq_done_next    = (state_next == S_RUN);
        timeout_err_next = (state_next == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_reg       <= S_PLL_RST;
            cnt_reg         <= '0;
            retry_reg       <= 4'd0;
            pll_reset_reg   <= 1'b1;
            gt_reset_reg    <= 1'b1;
            user_reset_reg  <= 1'b1;
            seq_done_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            retry_reg       <= retry_next;
            pll_reset_reg   <= pll_reset_next;
            gt_reset_reg    <= gt_reset_next;
            user_reset_reg  <= user_reset_next;
            seq_done_reg    <= seq_done_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign pll_reset   = pll_reset_reg;
    assign gt_reset    = gt_reset_reg;
    assign user_reset  = user_reset_reg;
    assign seq_done    = seq_done_reg;
    assign timeout_err = timeout_err_reg;
    assign retry_cnt   = retry_reg;

endmodule
